// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared width helper and default sizing for fifo_sync_param
// Rev 1.0
// ============================================================================
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int f_clog2(input int n);
        int r_bits;
        int r_val;
        r_bits = 0;
        r_val  = n - 1;
        while (r_val > 0) begin
            r_bits = r_bits + 1;
            r_val  = r_val >> 1;
        end
        return r_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// fifo_ram : DEPTH x DATA_WIDTH flop array, sync write / async read, no reset
// Rev 1.0
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = f_clog2(DEF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// fifo_sync_param : parametrised single-clock FIFO with level, almost flags,
//                   sticky error flags, flush and optional FWFT read port
// Rev 1.0
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int FWFT       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      w_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      r_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [f_clog2(DEPTH):0]   level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int c_PTR_W = f_clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_AF_LVL   = c_LVL_W'(DEPTH - AF_MARGIN);
    localparam logic [c_LVL_W-1:0] c_AE_LVL   = c_LVL_W'(AE_MARGIN);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_head;

    // Flags decode the stored level only, never this cycle's requests.
    assign empty        = (r_level == '0);
    assign full         = (r_level == c_FULL_LVL);
    assign almost_full  = (r_level >= c_AF_LVL);
    assign almost_empty = (r_level <= c_AE_LVL);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_rd_ok  = r_en && !empty;
    assign w_wr_ok  = w_en && (!full || w_rd_ok);
    assign w_ram_we = w_wr_ok && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= r_level + c_LVL_W'(w_wr_ok) - c_LVL_W'(w_rd_ok);
            if (w_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (r_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (c_PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : w_head;
        end else begin : g_std
            // Output register holds its value through flush; only reset clears it.
            logic [DATA_WIDTH-1:0] r_dout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (!flush && w_rd_ok) begin
                    r_dout <= w_head;
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// tb_fifo_sync_param : standard and FWFT instances driven in lockstep,
//                      checked against a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       w_en;
    logic       r_en;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] lvl0, lvl1;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .level(lvl0), .overflow(ovf0), .underflow(udf0)
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .level(lvl1), .overflow(ovf1), .underflow(udf1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus the sticky flags and the
    // registered output of the standard-mode port.
    logic [7:0] q[$];
    logic       m_ovf, m_udf;
    logic [7:0] m_dout0;

    typedef struct {
        logic       w, r;
        logic [7:0] d;
        int         lvl;
        logic       full, empty, af, ovf, udf;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d, input int lvl,
                                input logic fl, input logic em, input logic af, input logic ov,
                                input logic ud, input logic [7:0] dout);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.lvl = lvl; v.full = fl; v.empty = em;
        v.af = af; v.ovf = ov; v.udf = ud; v.dout = dout;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_dout0 = 8'h00;
    endtask

    task automatic model_step(input logic f, input logic w, input logic r, input logic [7:0] d);
        bit rd, wr;
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            rd = r && (q.size() > 0);
            wr = w && ((q.size() < 8) || rd);
            if (w && !wr) m_ovf = 1'b1;
            if (r && !rd) m_udf = 1'b1;
            if (rd) m_dout0 = q.pop_front();
            if (wr) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int sz;
        logic [7:0] head;
        sz   = q.size();
        head = (sz > 0) ? q[0] : 8'h00;
        chk("level0", 32'(lvl0), sz);
        chk("level1", 32'(lvl1), sz);
        chk("full0", 32'(full0), 32'(sz == 8));
        chk("full1", 32'(full1), 32'(sz == 8));
        chk("empty0", 32'(empty0), 32'(sz == 0));
        chk("empty1", 32'(empty1), 32'(sz == 0));
        chk("afull0", 32'(af0), 32'(sz >= 7));
        chk("afull1", 32'(af1), 32'(sz >= 7));
        chk("aempty0", 32'(ae0), 32'(sz <= 1));
        chk("aempty1", 32'(ae1), 32'(sz <= 1));
        chk("ovf0", 32'(ovf0), 32'(m_ovf));
        chk("ovf1", 32'(ovf1), 32'(m_ovf));
        chk("udf0", 32'(udf0), 32'(m_udf));
        chk("udf1", 32'(udf1), 32'(m_udf));
        chk("dout_std", 32'(dout0), 32'(m_dout0));
        chk("dout_fwft", 32'(dout1), 32'(head));
    endtask

    // Called on a falling edge; applies inputs across one rising edge and
    // checks at the next falling edge.
    task automatic step(input logic f, input logic w, input logic r, input logic [7:0] d);
        flush = f; w_en = w; r_en = r; data_in = d;
        @(posedge clk);
        model_step(f, w, r, d);
        @(negedge clk);
        check_all();
    endtask

    logic [7:0] exp_rd[8];

    initial begin
        // Test 1 and 2 vectors: fill to full, overflow, drain, underflow.
        for (int k = 0; k < 8; k++)
            vt[k] = mk(1'b1, 1'b0, 8'(8'h10 + k), k + 1, k == 7, 1'b0, k >= 6, 1'b0, 1'b0, 8'h00);
        vt[8] = mk(1'b1, 1'b0, 8'h99, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++)
            vt[9 + k] = mk(1'b0, 1'b1, 8'h00, 7 - k, 1'b0, k == 7, k == 0, 1'b1, 1'b0, 8'(8'h10 + k));
        vt[17] = mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h17);

        rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all();
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_aempty", 32'(ae0), 32'd1);

        for (int i = 0; i < 18; i++) begin
            step(1'b0, vt[i].w, vt[i].r, vt[i].d);
            chk($sformatf("vec%0d_level", i), 32'(lvl0), vt[i].lvl);
            chk($sformatf("vec%0d_full", i), 32'(full0), 32'(vt[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(empty0), 32'(vt[i].empty));
            chk($sformatf("vec%0d_afull", i), 32'(af0), 32'(vt[i].af));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf0), 32'(vt[i].ovf));
            chk($sformatf("vec%0d_udf", i), 32'(udf0), 32'(vt[i].udf));
            chk($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vt[i].dout));
        end

        // Test 3: simultaneous read/write on a full FIFO, then wrap-around drain.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t3_flush_ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'hA0 + i));
            chk("t3_rw_level", 32'(lvl0), 32'd8);
            chk("t3_rw_ovf", 32'(ovf0), 32'd0);
            chk("t3_rw_dout", 32'(dout0), 32'(8'h30 + i));
        end
        exp_rd = '{8'h34, 8'h35, 8'h36, 8'h37, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("t3_drain_dout", 32'(dout0), 32'(exp_rd[i]));
        end

        // Test 4: FWFT fall-through and pop.
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("t4_fwft_dout", 32'(dout1), 32'h5A);
        chk("t4_fwft_empty", 32'(empty1), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t4_pop_empty", 32'(empty1), 32'd1);
        chk("t4_pop_dout", 32'(dout1), 32'd0);

        // Test 5: flush beats a same-cycle write.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t5_pre_level", 32'(lvl0), 32'd5);
        chk("t5_pre_ovf", 32'(ovf0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("t5_level", 32'(lvl0), 32'd0);
        chk("t5_empty", 32'(empty0), 32'd1);
        chk("t5_ovf", 32'(ovf0), 32'd0);
        chk("t5_dout_hold", 32'(dout0), 32'h42);
        chk("t5_fwft_dout", 32'(dout1), 32'd0);

        // Test 6: asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        chk("t6_pre_level", 32'(lvl0), 32'd3);
        flush = 1'b0; w_en = 1'b1; r_en = 1'b0; data_in = 8'h63;
        #2 rst = 1'b1;
        #1;
        chk("t6_async_level", 32'(lvl0), 32'd0);
        chk("t6_async_empty", 32'(empty0), 32'd1);
        chk("t6_async_dout", 32'(dout0), 32'd0);
        chk("t6_async_fwft", 32'(dout1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; w_en = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        step(1'b0, 1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h78);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t6_first_read", 32'(dout0), 32'h77);

        // Randomized traffic: write-heavy, then read-heavy, with rare flushes.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 300) ? 70 : 30;
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < (100 - wp)),
                 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
